// File: rtl/sd_arbiter.sv
// Two-client block arbiter in front of one SD controller: grants whole blocks, issues the one-cycle rd/wr start, steers bytes.
// Grant and start appear 1 cycle after req; byte edge to strobe/dout is 1 cycle; the controller's sd_ready paces every transfer.
module sd_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int BLOCK_BYTES = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [1:0]  wr,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [7:0]  din0,
    input  logic [7:0]  din1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  byte_strobe,
    output logic [7:0]  dout,
    input  logic        sd_ready,
    output logic [31:0] sd_address,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic [7:0]  sd_dout,
    input  logic        sd_byte_available,
    output logic [7:0]  sd_din,
    input  logic        ready_for_next_byte
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, XFER, FINISH} state_t;

    localparam logic [9:0] BLK = 10'(BLOCK_BYTES);

    state_t      state, state_nxt;
    logic        owner, last, wr_q;
    logic        avail_q, rfnb_q;
    logic [9:0]  cnt;
    logic        winner, start, byte_edge, take_byte;
    logic [1:0]  own_oh;
    logic [31:0] sel_addr;

    always_comb begin
        winner = 1'b0;
        if (req == 2'b10)
            winner = 1'b1;
        else if (req == 2'b11 && ROUND_ROBIN != 0)
            winner = ~last;
        sel_addr  = winner ? addr1 : addr0;
        start     = (state == IDLE) && (req != 2'b00) && sd_ready;
        // Level inputs from the controller become one event per rising edge.
        byte_edge = wr_q ? (ready_for_next_byte & ~rfnb_q) : (sd_byte_available & ~avail_q);
        take_byte = (state == XFER) && byte_edge && (cnt < BLK);
        own_oh    = owner ? 2'b10 : 2'b01;
    end

    always_comb begin
        state_nxt = state;
        gnt       = 2'b00;
        done      = 2'b00;
        sd_rd     = 1'b0;
        sd_wr     = 1'b0;
        case (state)
            IDLE:      if (start) state_nxt = ISSUE;
            ISSUE: begin
                gnt       = own_oh;
                sd_rd     = ~wr_q;
                sd_wr     = wr_q;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                gnt = own_oh;
                if (!sd_ready) state_nxt = XFER;
            end
            // sd_ready high ends the block whether or not all bytes arrived.
            XFER: begin
                gnt = own_oh;
                if (sd_ready) state_nxt = FINISH;
            end
            FINISH: begin
                gnt       = own_oh;
                done      = own_oh;
                state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            wr_q        <= 1'b0;
            avail_q     <= 1'b0;
            rfnb_q      <= 1'b0;
            cnt         <= 10'd0;
            byte_strobe <= 2'b00;
            dout        <= 8'd0;
            sd_din      <= 8'd0;
            sd_address  <= 32'd0;
        end else begin
            state       <= state_nxt;
            avail_q     <= sd_byte_available;
            rfnb_q      <= ready_for_next_byte;
            byte_strobe <= 2'b00;
            if (start) begin
                owner      <= winner;
                wr_q       <= winner & wr[1];
                sd_address <= {sel_addr[31:9], 9'd0};
                cnt        <= 10'd0;
            end
            if (take_byte) begin
                cnt         <= cnt + 10'd1;
                byte_strobe <= own_oh;
                if (wr_q)
                    sd_din <= owner ? din1 : din0;
                else
                    dout <= sd_dout;
            end
            if (state == FINISH)
                last <= owner;
        end
    end

endmodule

// File: tb/tb_sd_arbiter.sv
// Directed bench for sd_arbiter: controller model tasks plus a negedge event monitor; a second instance runs with ROUND_ROBIN=0.
module tb_sd_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req = 2'b00, wr = 2'b00;
    logic [31:0] addr0 = 32'd0, addr1 = 32'd0;
    logic [7:0]  din0 = 8'd0, din1 = 8'd0;
    logic        sd_ready = 1'b1;
    logic [7:0]  sd_dout = 8'd0;
    logic        sd_byte_available = 1'b0, ready_for_next_byte = 1'b0;

    logic [1:0]  gnt, done, byte_strobe, b_gnt, b_done, b_byte_strobe;
    logic [7:0]  dout, sd_din, b_dout, b_sd_din;
    logic [31:0] sd_address, b_sd_address;
    logic        sd_rd, sd_wr, b_sd_rd, b_sd_wr;

    sd_arbiter #(.ROUND_ROBIN(1), .BLOCK_BYTES(512)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .addr0(addr0), .addr1(addr1),
        .din0(din0), .din1(din1), .gnt(gnt), .done(done), .byte_strobe(byte_strobe), .dout(dout),
        .sd_ready(sd_ready), .sd_address(sd_address), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_dout(sd_dout), .sd_byte_available(sd_byte_available), .sd_din(sd_din),
        .ready_for_next_byte(ready_for_next_byte)
    );

    sd_arbiter #(.ROUND_ROBIN(0), .BLOCK_BYTES(512)) dut_fixed (
        .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .addr0(addr0), .addr1(addr1),
        .din0(din0), .din1(din1), .gnt(b_gnt), .done(b_done), .byte_strobe(b_byte_strobe), .dout(b_dout),
        .sd_ready(sd_ready), .sd_address(b_sd_address), .sd_rd(b_sd_rd), .sd_wr(b_sd_wr),
        .sd_dout(sd_dout), .sd_byte_available(sd_byte_available), .sd_din(b_sd_din),
        .ready_for_next_byte(ready_for_next_byte)
    );

    always #20 clk = ~clk;

    int tests = 0, fails = 0;

    int n_rd = 0, n_wr = 0, n_s0 = 0, n_s1 = 0, n_d0 = 0, n_d1 = 0, n_viol = 0, n_bdiff = 0;
    logic [7:0] dout_cap[$];
    logic [7:0] din_cap[$];

    always @(negedge clk) begin
        n_rd += int'(sd_rd);
        n_wr += int'(sd_wr);
        n_s0 += int'(byte_strobe[0]);
        n_s1 += int'(byte_strobe[1]);
        n_d0 += int'(done[0]);
        n_d1 += int'(done[1]);
        if (((byte_strobe | done) & ~gnt) != 2'b00 || ((b_byte_strobe | b_done) & ~b_gnt) != 2'b00)
            n_viol++;
        if (b_dout !== dout || b_sd_din !== sd_din || b_sd_rd !== sd_rd || b_sd_wr !== sd_wr
            || b_sd_address !== sd_address)
            n_bdiff++;
        if (byte_strobe[0]) dout_cap.push_back(dout);
        if (byte_strobe[1]) din_cap.push_back(sd_din);
    end

    int          start_wait, done_wait;
    logic [1:0]  start_gnt, start_gnt_b;
    logic [31:0] start_addr;
    logic        start_rd, start_wr;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rd_model(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    task automatic emit(input bit is_wr, input int idx, input int hold);
        if (is_wr) begin
            din1 = 8'(idx);
            ready_for_next_byte = 1'b1;
        end else begin
            sd_dout = rd_model(idx);
            sd_byte_available = 1'b1;
        end
        repeat (hold) tick();
        ready_for_next_byte = 1'b0;
        sd_byte_available = 1'b0;
        tick();
    endtask

    task automatic run_block(input bit is_wr, input int nbytes, input int hold);
        start_wait = 0;
        while (!(sd_rd | sd_wr) && start_wait < 20) begin
            tick();
            start_wait++;
        end
        start_gnt = gnt; start_gnt_b = b_gnt; start_addr = sd_address;
        start_rd = sd_rd; start_wr = sd_wr;
        tests++;
        if (!(sd_rd | sd_wr)) begin
            fails++;
            $display("FAIL start_timeout: no sd_rd/sd_wr after %0d cycles, required within 20", start_wait);
        end
        sd_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < nbytes; i++) emit(is_wr, i, hold);
        sd_ready = 1'b1;
        done_wait = 0;
        while (done == 2'b00 && done_wait < 10) begin
            tick();
            done_wait++;
        end
        tests++;
        if (done == 2'b00) begin
            fails++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required pulse", done, done_wait);
        end
        tick();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req = 2'b00;
        repeat (3) tick();
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b, want 00", gnt); end
        tests++; if ({done, byte_strobe} !== 4'b0) begin fails++; $display("FAIL reset_pulses: got %b, want 0000", {done, byte_strobe}); end
        tests++; if ({sd_rd, sd_wr} !== 2'b00) begin fails++; $display("FAIL reset_start: got %b, want 00", {sd_rd, sd_wr}); end
        tests++; if (sd_address !== 32'd0) begin fails++; $display("FAIL reset_addr: got %h, want 0", sd_address); end
        tests++; if ({sd_din, dout} !== 16'd0) begin fails++; $display("FAIL reset_data: got %h, want 0", {sd_din, dout}); end
        reset_n = 1'b1;
        tick();
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL idle_no_req_gnt: got %b, want 00", gnt); end
    endtask

    task automatic test_single_read;
        int rd0 = n_rd, s0 = n_s0, d0 = n_d0, base = dout_cap.size(), bad = 0;
        addr0 = 32'h0000_0A00; wr = 2'b00; req = 2'b01;
        run_block(1'b0, 512, 1);
        req = 2'b00;
        tests++; if (start_wait != 1) begin fails++; $display("FAIL read_start_latency: got %0d, want 1", start_wait); end
        tests++; if (start_gnt !== 2'b01) begin fails++; $display("FAIL read_gnt: got %b, want 01", start_gnt); end
        tests++; if ({start_rd, start_wr} !== 2'b10) begin fails++; $display("FAIL read_cmd: got %b, want 10", {start_rd, start_wr}); end
        tests++; if (start_addr !== 32'h0000_0A00) begin fails++; $display("FAIL read_addr: got %h, want 00000a00", start_addr); end
        tests++; if (n_rd - rd0 != 1) begin fails++; $display("FAIL read_rd_pulses: got %0d, want 1", n_rd - rd0); end
        tests++; if (n_s0 - s0 != 512) begin fails++; $display("FAIL read_strobes: got %0d, want 512", n_s0 - s0); end
        for (int i = 0; i < 512 && base + i < dout_cap.size(); i++)
            if (dout_cap[base + i] !== rd_model(i)) bad++;
        tests++; if (bad != 0 || dout_cap.size() - base != 512) begin fails++; $display("FAIL read_dout_seq: %0d wrong of %0d captured, want 0 wrong of 512", bad, dout_cap.size() - base); end
        tests++; if (n_d0 - d0 != 1) begin fails++; $display("FAIL read_done: got %0d, want 1", n_d0 - d0); end
        tests++; if (done_wait != 1) begin fails++; $display("FAIL read_done_latency: got %0d, want 1", done_wait); end
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL read_gnt_release: got %b, want 00", gnt); end
    endtask

    task automatic test_write;
        int wr0 = n_wr, s0 = n_s0, s1 = n_s1, d1 = n_d1, base = din_cap.size(), bad = 0;
        addr1 = 32'h0000_0401; wr = 2'b10; req = 2'b10;
        run_block(1'b1, 512, 1);
        req = 2'b00; wr = 2'b00;
        tests++; if ({start_rd, start_wr} !== 2'b01) begin fails++; $display("FAIL write_cmd: got %b, want 01", {start_rd, start_wr}); end
        tests++; if (start_addr !== 32'h0000_0400) begin fails++; $display("FAIL write_addr: got %h, want 00000400", start_addr); end
        tests++; if (start_gnt !== 2'b10) begin fails++; $display("FAIL write_gnt: got %b, want 10", start_gnt); end
        tests++; if (n_wr - wr0 != 1) begin fails++; $display("FAIL write_wr_pulses: got %0d, want 1", n_wr - wr0); end
        tests++; if (n_s1 - s1 != 512 || n_s0 != s0) begin fails++; $display("FAIL write_strobes: got %0d/%0d, want 512/0", n_s1 - s1, n_s0 - s0); end
        for (int i = 0; i < 512 && base + i < din_cap.size(); i++)
            if (din_cap[base + i] !== 8'(i)) bad++;
        tests++; if (bad != 0 || din_cap.size() - base != 512) begin fails++; $display("FAIL write_din_seq: %0d wrong of %0d captured, want 0 wrong of 512", bad, din_cap.size() - base); end
        tests++; if (n_d1 - d1 != 1) begin fails++; $display("FAIL write_done: got %0d, want 1", n_d1 - d1); end
    endtask

    task automatic test_level_inputs;
        int s0 = n_s0, d0 = n_d0, base = dout_cap.size(), bad = 0;
        req = 2'b01;
        run_block(1'b0, 513, 3);
        req = 2'b00;
        tests++; if (n_s0 - s0 != 512) begin fails++; $display("FAIL level_strobes: got %0d, want 512", n_s0 - s0); end
        for (int i = 0; i < 512 && base + i < dout_cap.size(); i++)
            if (dout_cap[base + i] !== rd_model(i)) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL level_dout_seq: %0d wrong, want 0", bad); end
        tests++; if (n_d0 - d0 != 1) begin fails++; $display("FAIL level_done: got %0d, want 1", n_d0 - d0); end
    endtask

    task automatic test_round_robin;
        logic [1:0] ord_a[4], ord_b[4];
        logic [1:0] exp_a[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        addr0 = 32'h0000_2000; addr1 = 32'h0000_2000; wr = 2'b00; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            run_block(1'b0, 4, 1);
            ord_a[k] = start_gnt;
            ord_b[k] = start_gnt_b;
        end
        req = 2'b00;
        tests++; if (start_wait != 1) begin fails++; $display("FAIL rr_back_to_back_gap: got %0d, want 1", start_wait); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (ord_a[k] !== exp_a[k]) begin fails++; $display("FAIL rr_order[%0d]: got %b, want %b", k, ord_a[k], exp_a[k]); end
            tests++; if (ord_b[k] !== 2'b01) begin fails++; $display("FAIL fixed_order[%0d]: got %b, want 01", k, ord_b[k]); end
        end
    endtask

    task automatic test_short_block;
        int s0 = n_s0, d0 = n_d0;
        req = 2'b01;
        run_block(1'b0, 100, 1);
        tests++; if (n_s0 - s0 != 100) begin fails++; $display("FAIL short_strobes: got %0d, want 100", n_s0 - s0); end
        tests++; if (n_d0 - d0 != 1 || done_wait != 1) begin fails++; $display("FAIL short_done: got %0d after %0d, want 1 after 1", n_d0 - d0, done_wait); end
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL short_idle: got %b, want 00", gnt); end
        run_block(1'b0, 2, 1);
        req = 2'b00;
        tests++; if (start_wait != 1) begin fails++; $display("FAIL short_regrant: got %0d, want 1", start_wait); end
    endtask

    task automatic test_reset_mid;
        int w = 0, rd0, d0;
        req = 2'b01;
        while (!sd_rd && w < 20) begin tick(); w++; end
        tests++; if (!sd_rd) begin fails++; $display("FAIL rst_mid_start: no sd_rd after %0d cycles", w); end
        sd_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 200; i++) emit(1'b0, i, 1);
        d0 = n_d0;
        reset_n = 1'b0;
        tick();
        tests++; if ({gnt, done, byte_strobe} !== 6'b0) begin fails++; $display("FAIL rst_mid_ctrl: got %b, want 000000", {gnt, done, byte_strobe}); end
        tests++; if ({sd_rd, sd_wr, sd_address, sd_din, dout} !== 50'd0) begin fails++; $display("FAIL rst_mid_data: got rd=%b wr=%b addr=%h din=%h dout=%h, want all 0", sd_rd, sd_wr, sd_address, sd_din, dout); end
        reset_n = 1'b1;
        rd0 = n_rd;
        repeat (6) tick();
        tests++; if (n_rd != rd0 || gnt !== 2'b00) begin fails++; $display("FAIL rst_mid_wait_ready: %0d issues, gnt=%b, want 0 and 00", n_rd - rd0, gnt); end
        tests++; if (n_d0 != d0) begin fails++; $display("FAIL rst_mid_no_done: got %0d, want 0", n_d0 - d0); end
        sd_ready = 1'b1;
        run_block(1'b0, 3, 1);
        req = 2'b00;
        tests++; if (start_wait != 1 || start_gnt !== 2'b01) begin fails++; $display("FAIL rst_mid_resume: wait=%0d gnt=%b, want 1 and 01", start_wait, start_gnt); end
    endtask

    task automatic test_ownership;
        tests++; if (n_viol != 0) begin fails++; $display("FAIL non_owner_pulse: got %0d cycles, want 0", n_viol); end
        tests++; if (n_bdiff != 0) begin fails++; $display("FAIL fixed_prio_shared_outputs: got %0d differing cycles, want 0", n_bdiff); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_level_inputs();
        test_round_robin();
        test_short_block();
        test_reset_mid();
        test_ownership();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
